// File: rtl/inst_loader_pkg.sv
// Shared types for the instruction memory loader.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFlush,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/inst_loader.sv
// Instruction memory loader: streams words into a contiguous instruction memory region.
// Optional running checksum output enabled by INST_LOADER_CHECKSUM_EN.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned RegAddrWidth = 32,
  parameter int unsigned InstMemDepth = 128
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    cfg_start_i,
  input  logic [RegAddrWidth-1:0] cfg_base_addr_i,
  input  logic [RegAddrWidth-1:0] cfg_len_i,
  input  logic                    core_busy_i,
  input  logic [RegAddrWidth-1:0] s_data_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [RegAddrWidth-1:0] inst_wr_addr_o,
  output logic [RegAddrWidth-1:0] inst_wr_data_o,
  output logic                    inst_wr_en_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [RegAddrWidth-1:0] count_o
`ifdef INST_LOADER_CHECKSUM_EN
  ,
  output logic [RegAddrWidth-1:0] checksum_o
`endif
);

  localparam int unsigned InstMemAddrWidth = $clog2(InstMemDepth);
  localparam logic [RegAddrWidth:0] DepthExt = (RegAddrWidth + 1)'(InstMemDepth);
  localparam logic [RegAddrWidth-1:0] OneW = RegAddrWidth'(1);

  state_e                      state_q, state_d;
  logic [InstMemAddrWidth-1:0] base_q, base_d;
  logic [InstMemAddrWidth-1:0] wr_addr_q, wr_addr_d;
  logic [RegAddrWidth-1:0]     len_q, len_d;
  logic [RegAddrWidth-1:0]     count_q, count_d;
  logic [RegAddrWidth-1:0]     wr_data_q, wr_data_d;
  logic                        wr_en_q, wr_en_d;
  logic [RegAddrWidth:0]       end_addr;
  logic                        hs;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [RegAddrWidth-1:0]     checksum_q, checksum_d;
`endif

  // One extra bit so the bound check cannot wrap.
  assign end_addr = {1'b0, cfg_base_addr_i} + {1'b0, cfg_len_i};

  assign s_ready_o = (state_q == StLoad) && !core_busy_i;
  assign hs        = s_valid_i && s_ready_o;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    count_d   = count_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
    checksum_d = checksum_q;
`endif
    if (clr_i) begin
      state_d = StIdle;
      count_d = '0;
`ifdef INST_LOADER_CHECKSUM_EN
      checksum_d = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (cfg_start_i) begin
            count_d = '0;
            base_d  = cfg_base_addr_i[InstMemAddrWidth-1:0];
            len_d   = cfg_len_i;
`ifdef INST_LOADER_CHECKSUM_EN
            checksum_d = '0;
`endif
            if (core_busy_i || (end_addr > DepthExt)) begin
              state_d = StErr;
            end else if (cfg_len_i == '0) begin
              state_d = StDone;
            end else begin
              state_d = StLoad;
            end
          end
        end
        StLoad: begin
          if (hs) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base_q + count_q[InstMemAddrWidth-1:0];
            wr_data_d = s_data_i;
            count_d   = count_q + OneW;
`ifdef INST_LOADER_CHECKSUM_EN
            checksum_d = checksum_q + s_data_i;
`endif
            if (count_d == len_q) begin
              state_d = StFlush;
            end
          end
        end
        // The final write pulse is issued from the registered stage during this state.
        StFlush: state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      base_q    <= '0;
      len_q     <= '0;
      count_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      count_q   <= count_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
`ifdef INST_LOADER_CHECKSUM_EN
      checksum_q <= checksum_d;
`endif
    end
  end

  assign inst_wr_addr_o = {{(RegAddrWidth - InstMemAddrWidth){1'b0}}, wr_addr_q};
  assign inst_wr_data_o = wr_data_q;
  assign inst_wr_en_o   = wr_en_q;
  assign busy_o         = (state_q == StLoad) || (state_q == StFlush);
  assign done_o         = (state_q == StDone);
  assign err_o          = (state_q == StErr);
  assign count_o        = count_q;
`ifdef INST_LOADER_CHECKSUM_EN
  assign checksum_o     = checksum_q;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        cfg_start;
  logic [31:0] cfg_base;
  logic [31:0] cfg_len;
  logic        core_busy;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] count;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [31:0] words[8];
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];

  inst_loader #(
    .RegAddrWidth(32),
    .InstMemDepth(128)
  ) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clr_i          (clr),
    .cfg_start_i    (cfg_start),
    .cfg_base_addr_i(cfg_base),
    .cfg_len_i      (cfg_len),
    .core_busy_i    (core_busy),
    .s_data_i       (s_data),
    .s_valid_i      (s_valid),
    .s_ready_o      (s_ready),
    .inst_wr_addr_o (wr_addr),
    .inst_wr_data_o (wr_data),
    .inst_wr_en_o   (wr_en),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .count_o        (count)
`ifdef INST_LOADER_CHECKSUM_EN
    ,
    .checksum_o     (checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write log sampled mid-cycle, while registered outputs are stable.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      wc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic start(input logic [31:0] base, input logic [31:0] len);
    @(negedge clk);
    cfg_start = 1'b1;
    cfg_base  = base;
    cfg_len   = len;
    @(negedge clk);
    cfg_start = 1'b0;
    #1;
  endtask

  // Streams words[first +: n]; optionally raises core_busy for 3 cycles before word stall_at.
  task automatic stream(input int first, input int n, input int stall_at);
    int i = first;
    int budget = 0;
    bit stalled = 0;
    while (i < first + n && budget < 200) begin
      @(negedge clk);
      if (i == stall_at && !stalled) begin
        stalled   = 1;
        core_busy = 1'b1;
        s_valid   = 1'b1;
        s_data    = words[i];
        repeat (3) begin
          #1;
          check("stall_ready", {31'd0, s_ready}, 32'd0);
          @(negedge clk);
        end
        core_busy = 1'b0;
      end
      s_valid = 1'b1;
      s_data  = words[i];
      #1;
      if (s_ready) i++;
      budget++;
    end
    check("stream_words", i, first + n);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; cfg_start = 1'b0; cfg_base = '0; cfg_len = '0;
    core_busy = 1'b0; s_data = '0; s_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_wr_en", {31'd0, wr_en}, 0);
    check("rst_ready", {31'd0, s_ready}, 0);
    check("rst_count", count, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Base 4, len 3, back-to-back words.
    words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
    clear_log();
    start(4, 3);
    check("s1_busy_load", {31'd0, busy}, 1);
    stream(0, 3, -1);
    check("s1_flush_busy", {31'd0, busy}, 1);
    check("s1_flush_done", {31'd0, done}, 0);
    check("s1_flush_wr", {31'd0, wr_en}, 1);
    @(negedge clk); #1;
    check("s1_done", {31'd0, done}, 1);
    check("s1_busy_off", {31'd0, busy}, 0);
    check("s1_count", count, 3);
`ifdef INST_LOADER_CHECKSUM_EN
    check("s1_checksum", checksum, 32'h21);
`endif
    check("s1_nwr", wa.size(), 3);
    if (wa.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check("s1_addr", wa[k], 4 + k);
        check("s1_data", wd[k], 32'hA + k);
      end
      check("s1_gap01", wc[1] - wc[0], 1);
      check("s1_gap12", wc[2] - wc[1], 1);
    end

    // Out-of-range region.
    clear_log();
    s_valid = 1'b1;
    s_data  = 32'h55;
    start(120, 9);
    check("s2_err", {31'd0, err}, 1);
    check("s2_busy", {31'd0, busy}, 0);
    repeat (3) begin
      check("s2_ready", {31'd0, s_ready}, 0);
      @(negedge clk); #1;
    end
    check("s2_nwr", wa.size(), 0);
    s_valid = 1'b0;

    // Start while the core runs is rejected.
    core_busy = 1'b1;
    start(0, 2);
    check("s3_err", {31'd0, err}, 1);
    core_busy = 1'b0;

    // Core stalls the stream after 2 of 5 words.
    words[0] = 32'h100; words[1] = 32'h200; words[2] = 32'h300;
    words[3] = 32'h400; words[4] = 32'h500;
    clear_log();
    start(10, 5);
    check("s3_err_clr", {31'd0, err}, 0);
    stream(0, 5, 2);
    @(negedge clk); #1;
    check("s3_done", {31'd0, done}, 1);
    check("s3_count", count, 5);
`ifdef INST_LOADER_CHECKSUM_EN
    check("s3_checksum", checksum, 32'hF00);
`endif
    check("s3_nwr", wa.size(), 5);
    if (wa.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        check("s3_addr", wa[k], 10 + k);
        check("s3_data", wd[k], 32'h100 * (k + 1));
      end
    end

    // Zero-length load, then clr colliding with a start.
    clear_log();
    start(5, 0);
    check("s4_done", {31'd0, done}, 1);
    check("s4_busy", {31'd0, busy}, 0);
    check("s4_count", count, 0);
    @(negedge clk);
    clr = 1'b1; cfg_start = 1'b1; cfg_base = 0; cfg_len = 3;
    @(negedge clk);
    clr = 1'b0; cfg_start = 1'b0;
    #1;
    check("s4_clr_busy", {31'd0, busy}, 0);
    check("s4_clr_done", {31'd0, done}, 0);
    check("s4_nwr", wa.size(), 0);

    // clr on the 3rd handshake of 5 drops that write.
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    clear_log();
    start(20, 5);
    stream(0, 2, -1);
    @(negedge clk);
    s_valid = 1'b1; s_data = words[2]; clr = 1'b1;
    #1;
    check("s5_ready", {31'd0, s_ready}, 1);
    @(negedge clk);
    clr = 1'b0; s_valid = 1'b0;
    #1;
    check("s5_wr_en", {31'd0, wr_en}, 0);
    check("s5_count", count, 0);
    check("s5_busy", {31'd0, busy}, 0);
    check("s5_ready_off", {31'd0, s_ready}, 0);
`ifdef INST_LOADER_CHECKSUM_EN
    check("s5_checksum", checksum, 0);
`endif
    @(negedge clk); #1;
    check("s5_nwr", wa.size(), 2);

    // Start during LOAD is ignored.
    words[0] = 32'h1; words[1] = 32'h2; words[2] = 32'h3; words[3] = 32'h4;
    clear_log();
    start(30, 4);
    stream(0, 2, -1);
    @(negedge clk);
    cfg_start = 1'b1; cfg_base = 50; cfg_len = 1;
    @(negedge clk);
    cfg_start = 1'b0;
    #1;
    check("s6_busy", {31'd0, busy}, 1);
    check("s6_count", count, 2);
    stream(2, 2, -1);
    @(negedge clk); #1;
    check("s6_done", {31'd0, done}, 1);
    check("s6_count_end", count, 4);
    check("s6_nwr", wa.size(), 4);
    if (wa.size() == 4) begin
      for (int k = 0; k < 4; k++) check("s6_addr", wa[k], 30 + k);
    end

    // Asynchronous reset in the middle of a load.
    start(40, 3);
    s_valid = 1'b1; s_data = 32'h77;
    @(negedge clk);
    #1;
    check("s7_wr_pending", {31'd0, wr_en}, 1);
    rst_n = 1'b0;
    #1;
    check("s7_wr_en", {31'd0, wr_en}, 0);
    check("s7_busy", {31'd0, busy}, 0);
    check("s7_count", count, 0);
    check("s7_ready", {31'd0, s_ready}, 0);
    check("s7_addr", wr_addr, 0);
    check("s7_data", wr_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Instruction memory loader. Accepts a valid/ready stream of 32-bit instruction words from the host-side streamer and drives the instruction memory write port (write address, data, enable) of the instruction control block. It loads a contiguous region starting at a configured base address and refuses to write while the core is executing. It reports busy, done and error status to the CSR block.

## Interface
- RegAddrWidth, 32, width of data words, configuration registers and write address port
- InstMemDepth, 128, number of instruction memory entries
- InstMemAddrWidth, $clog2(InstMemDepth), internal address width; derived, do not override
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- clr_i  input  1  synchronous clear; returns the block to IDLE and zeroes counters
- cfg_start_i  input  1  single-cycle pulse; begins a load
- cfg_base_addr_i  input  RegAddrWidth  first memory entry to write
- cfg_len_i  input  RegAddrWidth  number of words to load
- core_busy_i  input  1  high while instruction control is executing (its enable)
- s_data_i  input  RegAddrWidth  instruction word
- s_valid_i  input  1  stream valid
- s_ready_o  output  1  stream ready
- inst_wr_addr_o  output  RegAddrWidth  memory write address, zero-extended from InstMemAddrWidth
- inst_wr_data_o  output  RegAddrWidth  memory write data
- inst_wr_en_o  output  1  memory write enable
- busy_o  output  1  high in LOAD or FLUSH
- done_o  output  1  level; high in DONE
- err_o  output  1  level; high in ERR
- count_o  output  RegAddrWidth  words accepted in the current or last load
- checksum_o  output  RegAddrWidth  present only with the macro (see Configuration)

## Operation
- States: IDLE, LOAD, FLUSH, DONE, ERR.
- cfg_start_i is accepted in IDLE, DONE or ERR. It clears count_o, and clears checksum_o when present. It latches base and length. Next state:
  - ERR if core_busy_i is high.
  - ERR if base + len > InstMemDepth. Compute the sum in RegAddrWidth+1 bits so it cannot overflow.
  - DONE if len == 0.
  - LOAD otherwise.
- cfg_start_i in LOAD or FLUSH is ignored.
- LOAD:
  - s_ready_o = (state == LOAD) && !core_busy_i. It never depends on s_valid_i.
  - On each handshake: register the word and write address base + count, pulse inst_wr_en_o for one cycle, and increment count.
  - On the handshake where count reaches len, go to FLUSH.
- FLUSH: one cycle; carries the final write pulse; then go to DONE.
- DONE and ERR hold until cfg_start_i or clr_i.
- Addresses never wrap; the bound check guarantees base + count < InstMemDepth.
- clr_i has priority over everything:
  - Go to IDLE.
  - Zero count and checksum.
  - Force inst_wr_en_o low in the next cycle, dropping any pending write.
- core_busy_i rising during LOAD only stalls the stream. It is not an error.

## Timing
- Reset: state IDLE; every output 0.
- Write latency: a handshake in cycle N gives inst_wr_en_o high in cycle N+1, with registered address and data. The memory commits at the end of N+1.
- Back-to-back handshakes give one write per cycle at full throughput.
- Final handshake in cycle N:
  - FLUSH in N+1.
  - DONE and done_o in N+2, when all words are readable.
  - busy_o low from N+2.
- A start rejected to ERR gives err_o high the next cycle, with no writes and s_ready_o never high.
- A len == 0 start gives done_o high the next cycle.
- clr_i and cfg_start_i in the same cycle: clr_i wins and the start is dropped.
- Reset mid-load: immediate IDLE; all outputs 0.

## Configuration
- Macro: INST_LOADER_CHECKSUM_EN.
- Defined:
  - checksum_o port exists.
  - checksum_o holds the running sum of every accepted word, modulo 2^RegAddrWidth.
  - It updates in the cycle after each handshake.
  - It is cleared by an accepted start, by clr_i and by reset.
- Undefined: checksum_o port and accumulator are absent. All other behaviour is identical.

## Structure
- Shared package inst_loader_pkg holds the state enum typedef (IDLE, LOAD, FLUSH, DONE, ERR).
- The design is a single module: one FSM plus an address, count and checksum datapath.
- No sub-module is needed.

## Test plan
- Base 4, len 3, words 0xA, 0xB, 0xC with valid held high -> three writes at addresses 4, 5, 6 on consecutive cycles; done_o two cycles after the last handshake; count_o 3; checksum_o 0x21.
- Base 120, len 9 with InstMemDepth 128 -> err_o high the next cycle; no inst_wr_en_o; s_ready_o stays 0.
- Start with core_busy_i high -> ERR. Then raise core_busy_i mid-load after 2 of 5 words -> s_ready_o low while busy; load resumes; writes at base+2..base+4; done_o.
- Len 0 -> done_o high the next cycle; no writes.
- clr_i the same cycle as the 3rd handshake of 5 -> no write pulse in the following cycle; IDLE; count_o 0.
- Start pulse during LOAD -> ignored; base, length and count are unchanged.
